// File: rtl/debounce_event_pkg.sv
// Shared helpers for the debounce_event slice: counter width computation.
package debounce_event_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

  // Register width able to hold v distinct states, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, tick-driven sample register, level,
// edge pulses, long-press hold and optional auto-repeat.
module debounce_channel
  import debounce_event_pkg::*;
#(
  parameter int unsigned SYNC_N       = 2,
  parameter int unsigned N            = 4,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter int unsigned REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic hold,
  output logic auto_repeat
);

  localparam int unsigned HW = cnt_width(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

  logic [SYNC_N-1:0] sync;
  logic [N-1:0]      samp;
  logic [HW-1:0]     hcnt;
  logic              set_lvl;
  logic              clr_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      samp <= '0;
    end else begin
      sync <= {sync[SYNC_N-2:0], in};
      if (tick) samp <= {samp[N-2:0], sync[SYNC_N-1]};
    end
  end

  assign set_lvl = (&samp) & ~out;
  assign clr_lvl = ~(|samp) & out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      hcnt <= '0;
    end else begin
      rise <= set_lvl;
      fall <= clr_lvl;
      if (set_lvl)      out <= 1'b1;
      else if (clr_lvl) out <= 1'b0;
      // Clearing on the falling update lets hold drop together with fall.
      if (clr_lvl)
        hcnt <= '0;
      else if (tick && out && hcnt != HOLD_MAX)
        hcnt <= hcnt + HW'(1);
    end
  end

  assign hold = (hcnt == HOLD_MAX);

  if (REPEAT_EN != 0) begin : g_rep
    localparam int unsigned RW = cnt_width(REPEAT_TICKS);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

    logic [RW-1:0] rcnt;
    logic          hold_entry;

    assign hold_entry = tick & out & ~clr_lvl & (hcnt == HOLD_MAX - HW'(1));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rcnt        <= '0;
        auto_repeat <= 1'b0;
      end else begin
        auto_repeat <= 1'b0;
        if (hold_entry) begin
          auto_repeat <= 1'b1;
          rcnt        <= '0;
        end else if (!hold || clr_lvl) begin
          rcnt <= '0;
        end else if (tick) begin
          if (rcnt == REP_LAST) begin
            auto_repeat <= 1'b1;
            rcnt        <= '0;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
      end
    end
  end else begin : g_norep
    assign auto_repeat = 1'b0;
  end

endmodule

// File: rtl/debounce_event.sv
// Multi-channel button/switch debouncer with edge, hold and auto-repeat events,
// all channels sampled on one shared prescaler tick.
module debounce_event
  import debounce_event_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SYNC_N       = 2,
  parameter int unsigned N            = 4,
  parameter int unsigned RATE         = 125000,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter int unsigned REPEAT_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] hold,
  output logic [WIDTH-1:0] auto_repeat,
  output logic             tick
);

  localparam int unsigned PW = cnt_width(RATE);
  localparam logic [PW-1:0] PRE_MAX = PW'(RATE - 1);

  logic [PW-1:0] pre_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    pre_cnt <= '0;
    else if (pre_cnt == PRE_MAX) pre_cnt <= '0;
    else                        pre_cnt <= pre_cnt + PW'(1);
  end

  assign tick = (pre_cnt == PRE_MAX);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_N      (SYNC_N),
      .N           (N),
      .HOLD_TICKS  (HOLD_TICKS),
      .REPEAT_TICKS(REPEAT_TICKS),
      .REPEAT_EN   (REPEAT_EN)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .in         (in[i]),
      .out        (out[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .hold       (hold[i]),
      .auto_repeat(auto_repeat[i])
    );
  end

endmodule

// File: tb/tb_debounce_event.sv
// Self-checking bench for debounce_event: directed scenarios plus random
// presses, compared every cycle against a run-length / tick-count model.
module tb_debounce_event;

  localparam int unsigned W    = 4;
  localparam int unsigned SN   = 2;
  localparam int unsigned N    = 4;
  localparam int unsigned RATE = 4;
  localparam int unsigned HOLD = 8;
  localparam int unsigned REP  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic [W-1:0] out1, rise1, fall1, hold1, rep1;
  logic [W-1:0] out0, rise0, fall0, hold0, rep0;
  logic         tick1, tick0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_event #(
    .WIDTH(W), .SYNC_N(SN), .N(N), .RATE(RATE),
    .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .in(din), .out(out1), .rise(rise1), .fall(fall1),
    .hold(hold1), .auto_repeat(rep1), .tick(tick1)
  );

  debounce_event #(
    .WIDTH(W), .SYNC_N(SN), .N(N), .RATE(RATE),
    .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .REPEAT_EN(0)
  ) dut0 (
    .clk(clk), .rst(rst), .in(din), .out(out0), .rise(rise0), .fall(fall0),
    .hold(hold0), .auto_repeat(rep0), .tick(tick0)
  );

  // Reference model: a debounced level follows the input once N consecutive
  // tick samples agree; hold/repeat derive from the number of ticks spent high.
  logic [W-1:0] e_out, e_rise, e_fall, e_hold, e_rep;
  logic         e_tick;

  always @(posedge clk or posedge rst) begin : model
    logic [W-1:0] hist [SN];
    logic [W-1:0] m_s, last_smp, n_out, n_rise, n_fall, n_hold, n_rep;
    int unsigned  run [W];
    int unsigned  hticks [W];
    int unsigned  edges;
    logic         nw;
    if (rst) begin
      for (int k = 0; k < SN; k++) hist[k] = '0;
      m_s = '0; last_smp = '0; edges = 0;
      for (int i = 0; i < W; i++) begin run[i] = N; hticks[i] = 0; end
      e_out <= '0; e_rise <= '0; e_fall <= '0; e_hold <= '0; e_rep <= '0; e_tick <= 1'b0;
    end else begin
      for (int i = 0; i < W; i++) begin
        nw = (run[i] >= N) ? last_smp[i] : e_out[i];
        n_out[i]  = nw;
        n_rise[i] = nw & ~e_out[i];
        n_fall[i] = e_out[i] & ~nw;
        n_rep[i]  = 1'b0;
        if (n_fall[i]) hticks[i] = 0;
        else if (e_tick && e_out[i]) begin
          hticks[i]++;
          n_rep[i] = (hticks[i] >= HOLD) && (((hticks[i] - HOLD) % REP) == 0);
        end
        n_hold[i] = (hticks[i] >= HOLD);
        if (e_tick) begin
          if (m_s[i] === last_smp[i]) begin
            if (run[i] < N) run[i]++;
          end else begin
            run[i] = 1;
            last_smp[i] = m_s[i];
          end
        end
      end
      m_s = hist[SN-2];
      for (int k = SN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = din;
      edges++;
      e_out <= n_out; e_rise <= n_rise; e_fall <= n_fall;
      e_hold <= n_hold; e_rep <= n_rep;
      e_tick <= ((edges % RATE) == RATE - 1);
    end
  end

  logic [5*W:0] got1, got0, exp1, exp0;
  assign got1 = {out1, rise1, fall1, hold1, rep1, tick1};
  assign got0 = {out0, rise0, fall0, hold0, rep0, tick0};
  assign exp1 = {e_out, e_rise, e_fall, e_hold, e_rep, e_tick};
  assign exp0 = {e_out, e_rise, e_fall, e_hold, {W{1'b0}}, e_tick};

  task automatic test_reset();
    rst = 1'b1;
    din = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (got1 !== '0 || got0 !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h/%h required=0", got1, got0);
    end
    rst = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      checks++;
      if (tick1 !== ((c % RATE) == RATE - 1)) begin
        errors++;
        $display("FAIL tick_phase cyc=%0d got=%b required=%b", c, tick1, ((c % RATE) == RATE - 1));
      end
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h required=%h", c, got1, exp1);
      end
    end
  endtask

  task automatic test_press();
    int unsigned rises = 0;
    int unsigned falls = 0;
    din[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL press_model cyc=%0d got=%h required=%h", c, got1, exp1);
      end
      if (rise1[0]) rises++;
    end
    checks++;
    if (out1[0] !== 1'b1 || rises != 1) begin
      errors++;
      $display("FAIL press_rise out=%b rises=%0d required out=1 rises=1", out1[0], rises);
    end
    din[0] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL release_model cyc=%0d got=%h required=%h", c, got1, exp1);
      end
      if (fall1[0]) falls++;
    end
    checks++;
    if (out1[0] !== 1'b0 || falls != 1) begin
      errors++;
      $display("FAIL release_fall out=%b falls=%0d required out=0 falls=1", out1[0], falls);
    end
  endtask

  task automatic test_glitch();
    int unsigned bad = 0;
    for (int c = 0; c < 40; c++) begin
      din[1] = (c < 10);
      @(negedge clk);
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL glitch_model cyc=%0d got=%h required=%h", c, got1, exp1);
      end
      if (out1[1] || rise1[1] || fall1[1]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_passed cycles_active=%0d required=0", bad);
    end
  endtask

  task automatic test_long_press();
    bit          found = 0;
    int unsigned reps = 0;
    int unsigned ticks = 0;
    int unsigned hold_at = 0;
    bit          prev_hold = 0;
    bit          fell = 0;
    din[2] = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL long_rise_model cyc=%0d got=%h required=%h", c, got1, exp1);
      end
      if (rise1[2]) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL long_rise_timeout rise=0 required=1");
    end
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL long_hold_model cyc=%0d got=%h required=%h", c, got1, exp1);
      end
      if (hold1[2] && hold_at == 0) hold_at = ticks;
      if (tick1) ticks++;
      if (rep1[2]) reps++;
    end
    checks++;
    if (hold_at != HOLD) begin
      errors++;
      $display("FAIL hold_entry ticks=%0d required=%0d", hold_at, HOLD);
    end
    checks++;
    if (reps != 6) begin
      errors++;
      $display("FAIL repeat_count got=%0d required=6", reps);
    end
    din[2] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      prev_hold = hold1[2];
      @(negedge clk);
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL long_release_model cyc=%0d got=%h required=%h", c, got1, exp1);
      end
      if (fall1[2]) begin
        fell = 1;
        checks++;
        if (hold1[2] !== 1'b0 || rep1[2] !== 1'b0 || !prev_hold) begin
          errors++;
          $display("FAIL hold_drop hold=%b rep=%b prev_hold=%b required 0,0,1", hold1[2], rep1[2], prev_hold);
        end
      end
    end
    checks++;
    if (!fell || out1[2] !== 1'b0) begin
      errors++;
      $display("FAIL long_release fell=%b out=%b required fell=1 out=0", fell, out1[2]);
    end
  endtask

  task automatic test_simultaneous();
    bit found = 0;
    int unsigned rep0_seen = 0;
    din = '1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (rise1 != '0) begin
        found = 1;
        checks++;
        if (rise1 !== 4'b1111 || rise0 !== 4'b1111) begin
          errors++;
          $display("FAIL simul_rise got=%b/%b required=1111", rise1, rise0);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL simul_timeout rise=0 required=1111");
    end
    @(negedge clk);
    checks++;
    if (rise1 !== 4'b0000) begin
      errors++;
      $display("FAIL simul_width got=%b required=0000", rise1);
    end
    for (int c = 0; c < 120; c++) begin
      if (c == 80) din = '0;
      @(negedge clk);
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL simul_model cyc=%0d got=%h required=%h", c, got1, exp1);
      end
      checks++;
      if (got0 !== exp0) begin
        errors++;
        $display("FAIL simul_norepeat_model cyc=%0d got=%h required=%h", c, got0, exp0);
      end
      if (rep0 != '0) rep0_seen++;
    end
    checks++;
    if (rep0_seen != 0) begin
      errors++;
      $display("FAIL repeat_disabled cycles=%0d required=0", rep0_seen);
    end
  endtask

  task automatic test_reset_mid_press();
    bit          found = 0;
    int unsigned ticks = 0;
    din[2] = 1'b1;
    for (int c = 0; c < 150 && !found; c++) begin
      @(negedge clk);
      if (hold1[2]) found = 1;
    end
    checks++;
    if (!found || out1[2] !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup hold=%b out=%b required=1,1", hold1[2], out1[2]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (got1 !== '0 || got0 !== '0) begin
      errors++;
      $display("FAIL midreset_clear got=%h/%h required=0", got1, got0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL midreset_model cyc=%0d got=%h required=%h", c, got1, exp1);
      end
      if (rise1[2]) found = 1;
      else if (tick1) ticks++;
    end
    checks++;
    if (!found || ticks != N) begin
      errors++;
      $display("FAIL midreset_rise found=%b ticks=%0d required=1,%0d", found, ticks, N);
    end
    found = 0;
    ticks = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL midreset_hold_model cyc=%0d got=%h required=%h", c, got1, exp1);
      end
      if (hold1[2]) found = 1;
      else if (tick1) ticks++;
    end
    checks++;
    if (!found || ticks != HOLD) begin
      errors++;
      $display("FAIL midreset_hold found=%b ticks=%0d required=1,%0d", found, ticks, HOLD);
    end
    din[2] = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_random();
    int unsigned tmr [W];
    for (int i = 0; i < W; i++) tmr[i] = $urandom_range(1, 40);
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      checks++;
      if (got1 !== exp1) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%h required=%h", c, got1, exp1);
      end
      checks++;
      if (got0 !== exp0) begin
        errors++;
        $display("FAIL random_norepeat_model cyc=%0d got=%h required=%h", c, got0, exp0);
      end
      for (int i = 0; i < W; i++) begin
        tmr[i]--;
        if (tmr[i] == 0) begin
          din[i] = ~din[i];
          tmr[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : $urandom_range(20, 90);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    din = '0;
    #1;
    test_reset();
    test_press();
    test_glitch();
    test_long_press();
    test_simultaneous();
    test_reset_mid_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
